iobus_timer_intr: RTL and testbench
===================================

// Module: iobus_timer_intr
// PURPOSE
//  Memory-mapped programmable down-counter timer on the OTTER IOBUS, acting as the
//  peripheral (responder) side of the bus: decodes IOBUS_ADDR/IOBUS_WR/IOBUS_OUT and
//  drives IOBUS_IN. It also generates the CPU INTR line.
//  Sits beside OTTER_TOP in the board wrapper; multiple instances use distinct BASE_ADDR.
// PARAMETERS
//  BASE_ADDR   32'h1100_0100  word-aligned base of the 4-register window (16 bytes)
//  PRESCALE    1              CLK cycles per count tick (>=1)
//  INTR_PULSE  2              cycles INTR is held high per expiry event (>=1)
// PORTS
//  CLK         in   1   system clock; all state changes on rising edge
//  RST         in   1   asynchronous, active-low reset
//  IOBUS_ADDR  in   32  byte address from CPU
//  IOBUS_OUT   in   32  write data from CPU
//  IOBUS_WR    in   1   write strobe, sampled on rising CLK
//  IOBUS_IN    out  32  read data to CPU, combinational from IOBUS_ADDR
//  INTR        out  1   interrupt pulse to CPU
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   0x0 CTRL   R/W  [0]EN [1]AUTO_RELOAD [2]INTR_EN; other bits read 0
//   0x4 LOAD   R/W  32-bit reload value
//   0x8 COUNT  RO   current count; writes ignored
//   0xC STATUS W1C  [0]PENDING; writing 1 to bit0 clears, 0 has no effect
//  Unmapped or non-window address: reads 0, writes ignored. Only ADDR[3:2] decodes inside the window.
//  Reset (RST=0, async): CTRL=0, LOAD=0, COUNT=0, PENDING=0, prescaler=0, INTR=0,
//   timer FSM=IDLE, interrupt FSM=I_IDLE. IOBUS_IN still follows the address decode.
//  Timer FSM:
//   IDLE: write to CTRL with EN=1 loads COUNT<=LOAD, prescaler<=0, moves to RUN.
//   RUN: the prescaler counts 0..PRESCALE-1. A tick fires when it equals PRESCALE-1.
//    On tick: if COUNT!=0 then COUNT<=COUNT-1. If COUNT==0, expire.
//    Expire: PENDING<=1. If INTR_EN, the interrupt FSM starts.
//     With AUTO_RELOAD=1: COUNT<=LOAD and the FSM stays in RUN.
//     With AUTO_RELOAD=0: CTRL.EN<=0, the FSM goes to IDLE, and COUNT stays 0.
//    A CTRL write with EN=0 goes to IDLE the next cycle. COUNT and the prescaler freeze.
//    A CTRL write with EN=1 while in RUN updates the mode bits only and does not reload.
//   Expiry period = (LOAD+1)*PRESCALE cycles. LOAD=0 expires on every tick.
//   A LOAD write while in RUN affects only the next reload or start.
//  Interrupt FSM:
//   I_IDLE -> I_ACTIVE on expire with INTR_EN=1. INTR=1 for exactly INTR_PULSE cycles,
//   starting the cycle after the expiring edge. It then returns to I_IDLE.
//   A new expire during I_ACTIVE restarts the pulse counter and extends the pulse.
//   Clearing INTR_EN during I_ACTIVE does not truncate the current pulse.
//  Simultaneous events:
//   Expire and a STATUS W1C in the same cycle: set wins, PENDING=1.
//   CTRL EN=0 write and a tick in the same cycle: the write wins, no decrement and no expire.
//  Width rules: COUNT is 32-bit unsigned. The decrement never wraps below 0.
//   The prescaler is $clog2(PRESCALE)+1 bits.
// TESTING
//  1 Reset: RST=0 mid-RUN with INTR high -> INTR=0, COUNT=0, CTRL reads 0 immediately (async).
//  2 One-shot: LOAD=3, CTRL=32'h5 written at edge k -> INTR=1 after edges k+4..k+5, PENDING=1,
//    CTRL reads 32'h4, COUNT=0.
//  3 Auto-reload: LOAD=1, CTRL=32'h7 -> INTR pulses every 2 cycles, stretched (continuously high);
//    LOAD=4 -> pulses 2 cycles wide every 5 cycles.
//  4 W1C race: write STATUS=1 on the expiring edge -> PENDING reads 1. Write STATUS=1 later -> reads 0.
//  5 Decode: write 32'hDEAD to BASE+0x8 and to BASE+0x10 -> COUNT unchanged, BASE+0x10 reads 0.
//  6 Stop/resume: PRESCALE=4, LOAD=10, CTRL EN=0 after 9 cycles -> COUNT holds 9.
//    Re-enabling reloads COUNT to 10.

Source files
------------

// File: rtl/iobus_timer_intr.sv
`default_nettype none
//==============================================================================
// Module      : iobus_timer_intr
// Description : IOBUS-mapped programmable down-counter timer with an
//               interrupt pulse generator for the OTTER CPU.
// Revision    : 1.0 - initial release
//==============================================================================
module iobus_timer_intr #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned INTR_PULSE = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  localparam int unsigned c_PRE_W = $clog2(PRESCALE) + 1;
  localparam int unsigned c_PLS_W = $clog2(INTR_PULSE) + 1;

  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
  localparam logic [c_PLS_W-1:0] c_PLS_LAST = c_PLS_W'(INTR_PULSE - 1);
  localparam logic [c_PLS_W-1:0] c_PLS_ONE  = c_PLS_W'(1);

  localparam logic [1:0] c_SEL_CTRL   = 2'd0;
  localparam logic [1:0] c_SEL_LOAD   = 2'd1;
  localparam logic [1:0] c_SEL_COUNT  = 2'd2;
  localparam logic [1:0] c_SEL_STATUS = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

  typedef enum logic [0:0] {
    I_IDLE   = 1'b0,
    I_ACTIVE = 1'b1
  } int_state_t;

  tmr_state_t r_tmr_state;
  tmr_state_t w_tmr_next;
  int_state_t r_int_state;
  int_state_t w_int_next;

  logic [2:0]         r_ctrl;      // [0]EN [1]AUTO_RELOAD [2]INTR_EN
  logic [31:0]        r_load;
  logic [31:0]        r_count;
  logic               r_pending;
  logic [c_PRE_W-1:0] r_presc;
  logic [c_PLS_W-1:0] r_pls;

  logic       w_in_window;
  logic [1:0] w_sel;
  logic       w_wr_ctrl;
  logic       w_wr_load;
  logic       w_wr_status;
  logic       w_run;
  logic       w_start;
  logic       w_stop;
  logic       w_tick;
  logic       w_expire;
  logic       w_int_start;
  logic       w_unused_addr;

  //--------------------------------------------------------------------------
  // Address decode: only ADDR[3:2] selects a register inside the window
  //--------------------------------------------------------------------------
  assign w_in_window   = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign w_sel         = IOBUS_ADDR[3:2];
  assign w_unused_addr = |IOBUS_ADDR[1:0];

  assign w_wr_ctrl   = IOBUS_WR & w_in_window & (w_sel == c_SEL_CTRL);
  assign w_wr_load   = IOBUS_WR & w_in_window & (w_sel == c_SEL_LOAD);
  assign w_wr_status = IOBUS_WR & w_in_window & (w_sel == c_SEL_STATUS);

  //--------------------------------------------------------------------------
  // Timer event qualifiers; a stop write overrides a coincident tick
  //--------------------------------------------------------------------------
  assign w_run       = (r_tmr_state == RUN);
  assign w_start     = w_wr_ctrl & IOBUS_OUT[0] & ~w_run;
  assign w_stop      = w_wr_ctrl & ~IOBUS_OUT[0];
  assign w_tick      = w_run & (r_presc == c_PRE_LAST);
  assign w_expire    = w_tick & ~w_stop & (r_count == 32'd0);
  assign w_int_start = w_expire & r_ctrl[2];

  //--------------------------------------------------------------------------
  // Timer FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tmr_state <= IDLE;
    end else begin
      r_tmr_state <= w_tmr_next;
    end
  end

  always_comb begin
    w_tmr_next = r_tmr_state;
    case (r_tmr_state)
      IDLE: begin
        if (w_start) begin
          w_tmr_next = RUN;
        end
      end
      RUN: begin
        if (w_stop) begin
          w_tmr_next = IDLE;
        end else if (w_expire && !r_ctrl[1]) begin
          w_tmr_next = IDLE;
        end
      end
      default: w_tmr_next = IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Control, reload and counting datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ctrl    <= 3'b000;
      r_load    <= 32'd0;
      r_count   <= 32'd0;
      r_presc   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= IOBUS_OUT[2:0];
      end
      // One-shot expiry drops EN even if the same edge rewrote CTRL
      if (w_expire && !r_ctrl[1]) begin
        r_ctrl[0] <= 1'b0;
      end

      if (w_wr_load) begin
        r_load <= IOBUS_OUT;
      end

      if (w_start) begin
        r_count <= r_load;
        r_presc <= '0;
      end else if (w_run && !w_stop) begin
        if (w_tick) begin
          r_presc <= '0;
          if (r_count != 32'd0) begin
            r_count <= r_count - 32'd1;
          end else if (r_ctrl[1]) begin
            r_count <= r_load;
          end
        end else begin
          r_presc <= r_presc + c_PRE_ONE;
        end
      end

      if (w_expire) begin
        r_pending <= 1'b1;
      end else if (w_wr_status && IOBUS_OUT[0]) begin
        r_pending <= 1'b0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Interrupt FSM: a fresh expiry restarts the pulse width count
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_int_state <= I_IDLE;
      r_pls       <= '0;
    end else begin
      r_int_state <= w_int_next;
      if (w_int_start) begin
        r_pls <= '0;
      end else if ((r_int_state == I_ACTIVE) && (r_pls != c_PLS_LAST)) begin
        r_pls <= r_pls + c_PLS_ONE;
      end
    end
  end

  always_comb begin
    w_int_next = r_int_state;
    case (r_int_state)
      I_IDLE: begin
        if (w_int_start) begin
          w_int_next = I_ACTIVE;
        end
      end
      I_ACTIVE: begin
        if (!w_int_start && (r_pls == c_PLS_LAST)) begin
          w_int_next = I_IDLE;
        end
      end
      default: w_int_next = I_IDLE;
    endcase
  end

  assign INTR = (r_int_state == I_ACTIVE);

  //--------------------------------------------------------------------------
  // Read mux
  //--------------------------------------------------------------------------
  always_comb begin
    IOBUS_IN = 32'd0;
    if (w_in_window) begin
      case (w_sel)
        c_SEL_CTRL:   IOBUS_IN = {29'd0, r_ctrl};
        c_SEL_LOAD:   IOBUS_IN = r_load;
        c_SEL_COUNT:  IOBUS_IN = r_count;
        c_SEL_STATUS: IOBUS_IN = {31'd0, r_pending};
        default:      IOBUS_IN = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iobus_timer_intr.sv
`default_nettype none
//==============================================================================
// Module      : tb_iobus_timer_intr
// Description : Directed self-checking bench for iobus_timer_intr; two
//               instances (PRESCALE 1 and 4) share one IOBUS.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_iobus_timer_intr;

    localparam logic [31:0] BASE_A = 32'h1100_0100;
    localparam logic [31:0] BASE_B = 32'h1100_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        intr_a;
    logic        intr_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iobus_timer_intr #(
        .BASE_ADDR (BASE_A),
        .PRESCALE  (1),
        .INTR_PULSE(2)
    ) u_dut_a (
        .CLK       (clk),
        .RST       (rst),
        .IOBUS_ADDR(addr),
        .IOBUS_OUT (wdata),
        .IOBUS_WR  (wr),
        .IOBUS_IN  (rdata_a),
        .INTR      (intr_a)
    );

    iobus_timer_intr #(
        .BASE_ADDR (BASE_B),
        .PRESCALE  (4),
        .INTR_PULSE(2)
    ) u_dut_b (
        .CLK       (clk),
        .RST       (rst),
        .IOBUS_ADDR(addr),
        .IOBUS_OUT (wdata),
        .IOBUS_WR  (wr),
        .IOBUS_IN  (rdata_b),
        .INTR      (intr_b)
    );

    task automatic report_fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        addr  = 32'd0;
        wdata = 32'd0;
        wr    = 1'b0;
        #1 rst = 1'b0;
        #1;

        rd(BASE_A + 32'h0);
        n_checks++; if (rdata_a !== 32'd0) report_fail("rst_ctrl", rdata_a, 32'd0);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd0) report_fail("rst_count", rdata_a, 32'd0);
        rd(BASE_A + 32'hC);
        n_checks++; if (rdata_a !== 32'd0) report_fail("rst_status", rdata_a, 32'd0);
        n_checks++; if (intr_a !== 1'b0) report_fail("rst_intr", {31'd0, intr_a}, 32'd0);
        step(2);
        rst = 1'b1;
        step(1);

        bus_write(BASE_A + 32'h4, 32'd3);
        rd(BASE_A + 32'h4);
        n_checks++; if (rdata_a !== 32'd3) report_fail("os_load_rb", rdata_a, 32'd3);
        bus_write(BASE_A + 32'h0, 32'h5);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd3) report_fail("os_count_k", rdata_a, 32'd3);
        step(3);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd0) report_fail("os_count_k3", rdata_a, 32'd0);
        n_checks++; if (intr_a !== 1'b0) report_fail("os_intr_k3", {31'd0, intr_a}, 32'd0);
        step(1);
        n_checks++; if (intr_a !== 1'b1) report_fail("os_intr_k4", {31'd0, intr_a}, 32'd1);
        rd(BASE_A + 32'hC);
        n_checks++; if (rdata_a !== 32'd1) report_fail("os_pending", rdata_a, 32'd1);
        rd(BASE_A + 32'h0);
        n_checks++; if (rdata_a !== 32'h4) report_fail("os_ctrl", rdata_a, 32'h4);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd0) report_fail("os_count_k4", rdata_a, 32'd0);
        step(1);
        n_checks++; if (intr_a !== 1'b1) report_fail("os_intr_k5", {31'd0, intr_a}, 32'd1);
        step(1);
        n_checks++; if (intr_a !== 1'b0) report_fail("os_intr_k6", {31'd0, intr_a}, 32'd0);
        step(3);
        n_checks++; if (intr_a !== 1'b0) report_fail("os_intr_idle", {31'd0, intr_a}, 32'd0);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd0) report_fail("os_count_idle", rdata_a, 32'd0);

        bus_write(BASE_A + 32'hC, 32'd0);
        rd(BASE_A + 32'hC);
        n_checks++; if (rdata_a !== 32'd1) report_fail("w1c_zero", rdata_a, 32'd1);
        bus_write(BASE_A + 32'hC, 32'd1);
        rd(BASE_A + 32'hC);
        n_checks++; if (rdata_a !== 32'd0) report_fail("w1c_clear", rdata_a, 32'd0);
        bus_write(BASE_A + 32'h4, 32'd0);
        bus_write(BASE_A + 32'h0, 32'h1);
        bus_write(BASE_A + 32'hC, 32'd1);
        rd(BASE_A + 32'hC);
        n_checks++; if (rdata_a !== 32'd1) report_fail("w1c_race", rdata_a, 32'd1);
        rd(BASE_A + 32'h0);
        n_checks++; if (rdata_a !== 32'd0) report_fail("w1c_ctrl", rdata_a, 32'd0);
        n_checks++; if (intr_a !== 1'b0) report_fail("w1c_no_intr", {31'd0, intr_a}, 32'd0);
        bus_write(BASE_A + 32'hC, 32'd1);
        rd(BASE_A + 32'hC);
        n_checks++; if (rdata_a !== 32'd0) report_fail("w1c_later", rdata_a, 32'd0);

        bus_write(BASE_A + 32'h4, 32'd1);
        bus_write(BASE_A + 32'h0, 32'h7);
        step(1);
        n_checks++; if (intr_a !== 1'b0) report_fail("ar1_intr_k1", {31'd0, intr_a}, 32'd0);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd0) report_fail("ar1_count_k1", rdata_a, 32'd0);
        step(1);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar1_intr_k2", {31'd0, intr_a}, 32'd1);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd1) report_fail("ar1_reload", rdata_a, 32'd1);
        step(3);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar1_intr_k5", {31'd0, intr_a}, 32'd1);
        step(3);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar1_intr_k8", {31'd0, intr_a}, 32'd1);
        bus_write(BASE_A + 32'h0, 32'h0);
        n_checks++; if (intr_a !== 1'b1) report_fail("stop_intr_hold", {31'd0, intr_a}, 32'd1);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd1) report_fail("stop_count", rdata_a, 32'd1);
        step(1);
        n_checks++; if (intr_a !== 1'b0) report_fail("stop_intr_end", {31'd0, intr_a}, 32'd0);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd1) report_fail("stop_count_frozen", rdata_a, 32'd1);

        bus_write(BASE_A + 32'h4, 32'd4);
        bus_write(BASE_A + 32'h0, 32'h7);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd4) report_fail("ar4_start", rdata_a, 32'd4);
        step(4);
        n_checks++; if (intr_a !== 1'b0) report_fail("ar4_intr_m4", {31'd0, intr_a}, 32'd0);
        step(1);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar4_intr_m5", {31'd0, intr_a}, 32'd1);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd4) report_fail("ar4_reload", rdata_a, 32'd4);
        step(1);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar4_intr_m6", {31'd0, intr_a}, 32'd1);
        step(1);
        n_checks++; if (intr_a !== 1'b0) report_fail("ar4_intr_m7", {31'd0, intr_a}, 32'd0);
        step(3);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar4_intr_m10", {31'd0, intr_a}, 32'd1);
        step(1);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar4_intr_m11", {31'd0, intr_a}, 32'd1);
        step(1);
        n_checks++; if (intr_a !== 1'b0) report_fail("ar4_intr_m12", {31'd0, intr_a}, 32'd0);
        bus_write(BASE_A + 32'h0, 32'h0);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd2) report_fail("ar4_stop_count", rdata_a, 32'd2);

        bus_write(BASE_A + 32'h8, 32'hDEAD);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd2) report_fail("dec_count_ro", rdata_a, 32'd2);
        bus_write(BASE_A + 32'h10, 32'hDEAD);
        rd(BASE_A + 32'h10);
        n_checks++; if (rdata_a !== 32'd0) report_fail("dec_outside_rd", rdata_a, 32'd0);
        rd(BASE_A + 32'h0);
        n_checks++; if (rdata_a !== 32'd0) report_fail("dec_no_alias", rdata_a, 32'd0);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd2) report_fail("dec_count_keep", rdata_a, 32'd2);
        bus_write(BASE_A + 32'h0, 32'hFFFF_FFF8);
        rd(BASE_A + 32'h0);
        n_checks++; if (rdata_a !== 32'd0) report_fail("dec_ctrl_hi0", rdata_a, 32'd0);
        bus_write(BASE_A + 32'h4, 32'hDEAD_BEEF);
        rd(BASE_A + 32'h4);
        n_checks++; if (rdata_a !== 32'hDEAD_BEEF) report_fail("dec_load_rb", rdata_a, 32'hDEAD_BEEF);
        rd(BASE_B + 32'h4);
        n_checks++; if (rdata_b !== 32'd0) report_fail("dec_b_load", rdata_b, 32'd0);
        n_checks++; if (rdata_a !== 32'd0) report_fail("dec_a_at_b", rdata_a, 32'd0);

        bus_write(BASE_B + 32'h4, 32'd10);
        bus_write(BASE_B + 32'h0, 32'h1);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd10) report_fail("sr_start", rdata_b, 32'd10);
        step(7);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd9) report_fail("sr_first_tick", rdata_b, 32'd9);
        bus_write(BASE_B + 32'h0, 32'h0);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd9) report_fail("sr_stop_wins", rdata_b, 32'd9);
        step(8);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd9) report_fail("sr_frozen", rdata_b, 32'd9);
        bus_write(BASE_B + 32'h0, 32'h1);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd10) report_fail("sr_reload", rdata_b, 32'd10);
        step(3);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd10) report_fail("sr_presc_clr", rdata_b, 32'd10);
        step(1);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd9) report_fail("sr_tick_again", rdata_b, 32'd9);
        n_checks++; if (intr_b !== 1'b0) report_fail("sr_no_intr", {31'd0, intr_b}, 32'd0);

        bus_write(BASE_A + 32'h4, 32'd0);
        bus_write(BASE_A + 32'h0, 32'h7);
        step(2);
        n_checks++; if (intr_a !== 1'b1) report_fail("ar_intr_high", {31'd0, intr_a}, 32'd1);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (intr_a !== 1'b0) report_fail("ar_intr_low", {31'd0, intr_a}, 32'd0);
        rd(BASE_A + 32'h0);
        n_checks++; if (rdata_a !== 32'd0) report_fail("ar_ctrl", rdata_a, 32'd0);
        rd(BASE_A + 32'h8);
        n_checks++; if (rdata_a !== 32'd0) report_fail("ar_count", rdata_a, 32'd0);
        rd(BASE_A + 32'hC);
        n_checks++; if (rdata_a !== 32'd0) report_fail("ar_status", rdata_a, 32'd0);
        rd(BASE_B + 32'h8);
        n_checks++; if (rdata_b !== 32'd0) report_fail("ar_b_count", rdata_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
